// File: rtl/event_cond_pkg.sv
// Shared register map and detection-mode encoding for the APB event conditioner.
package event_cond_pkg;

    localparam logic [2:0] REG_MODE_LO = 3'd0;
    localparam logic [2:0] REG_MODE_HI = 3'd1;
    localparam logic [2:0] REG_MASK    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CNT_SEL = 3'd4;
    localparam logic [2:0] REG_CNT     = 3'd5;

    localparam logic [2:0] REGS_MAX_ADR = REG_CNT;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_RISE  = 2'b01,
        MODE_FALL  = 2'b10,
        MODE_ANY   = 2'b11
    } mode_e;

endpackage

// File: rtl/event_sync_edge.sv
// One event line: multi-flop synchroniser, previous-value register and mode-selected detector.
module event_sync_edge
    import event_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       event_i,
    input  logic [1:0] mode_i,
    output logic       det_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   s;
    mode_e                  mode;

    assign s    = sync_q[SYNC_STAGES-1];
    assign mode = mode_e'(mode_i);

    // prev tracks s regardless of mode so a mode switch never creates a false edge
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], event_i};
        prev_d = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        det_o = 1'b0;
        case (mode)
            MODE_LEVEL: det_o = s;
            MODE_RISE:  det_o = s & ~prev_q;
            MODE_FALL:  det_o = ~s & prev_q;
            MODE_ANY:   det_o = s ^ prev_q;
            default:    det_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_event_conditioner.sv
// APB-programmable conditioner: 32 synchronised event lines with per-line mode, mask,
// sticky status, a selectable debug counter and a registered conditioned output.
module apb_event_conditioner
    import event_cond_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               event_i,
    output logic [31:0]               signal_o
);

    localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

    logic [31:0]          mode_lo_q, mode_lo_d;
    logic [31:0]          mode_hi_q, mode_hi_d;
    logic [31:0]          mask_q, mask_d;
    logic [31:0]          status_q, status_d;
    logic [4:0]           cnt_sel_q, cnt_sel_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           warm_cnt_q, warm_cnt_d;
    logic [31:0]          signal_q, signal_d;

    logic        wr_en, rd_en, warm, sel_hit;
    logic [2:0]  reg_idx;
    logic [63:0] mode_all;
    logic [31:0] det, hit, w1c_mask;
    logic        unused_paddr;

    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign rd_en        = PSEL & PENABLE & ~PWRITE;
    assign reg_idx      = PADDR[4:2];
    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};
    assign mode_all     = {mode_hi_q, mode_lo_q};
    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;
    assign signal_o     = signal_q;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_line
            event_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_line (
                .clk    (HCLK),
                .rst_n  (HRESETn),
                .event_i(event_i[gi]),
                .mode_i (mode_all[2*gi +: 2]),
                .det_o  (det[gi])
            );
        end
    endgenerate

    // warm stays low until the synchronisers have flushed their reset contents
    assign warm       = (warm_cnt_q == WARM_LAST);
    assign warm_cnt_d = warm ? warm_cnt_q : warm_cnt_q + 3'd1;

    assign hit      = det & ~mask_q & {32{warm}};
    assign sel_hit  = hit[cnt_sel_q];
    assign w1c_mask = (wr_en && reg_idx == REG_STATUS) ? PWDATA : 32'h0;

    always_comb begin
        mode_lo_d = mode_lo_q;
        mode_hi_d = mode_hi_q;
        mask_d    = mask_q;
        cnt_sel_d = cnt_sel_q;
        cnt_d     = cnt_q;
        signal_d  = hit;

        if (wr_en) begin
            case (reg_idx)
                REG_MODE_LO: mode_lo_d = PWDATA;
                REG_MODE_HI: mode_hi_d = PWDATA;
                REG_MASK:    mask_d    = PWDATA;
                REG_CNT_SEL: cnt_sel_d = PWDATA[4:0];
                default:     ;
            endcase
        end

        // a new detect in the same cycle as a clear survives the clear
        status_d = (status_q & ~w1c_mask) | hit;

        if (wr_en && reg_idx == REG_CNT) begin
            cnt_d = sel_hit ? CNT_WIDTH'(1) : '0;
        end else if (sel_hit && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_lo_q  <= '0;
            mode_hi_q  <= '0;
            mask_q     <= '0;
            status_q   <= '0;
            cnt_sel_q  <= '0;
            cnt_q      <= '0;
            warm_cnt_q <= '0;
            signal_q   <= '0;
        end else begin
            mode_lo_q  <= mode_lo_d;
            mode_hi_q  <= mode_hi_d;
            mask_q     <= mask_d;
            status_q   <= status_d;
            cnt_sel_q  <= cnt_sel_d;
            cnt_q      <= cnt_d;
            warm_cnt_q <= warm_cnt_d;
            signal_q   <= signal_d;
        end
    end

    always_comb begin
        PRDATA = 32'h0;
        if (rd_en && reg_idx <= REGS_MAX_ADR) begin
            case (reg_idx)
                REG_MODE_LO: PRDATA = mode_lo_q;
                REG_MODE_HI: PRDATA = mode_hi_q;
                REG_MASK:    PRDATA = mask_q;
                REG_STATUS:  PRDATA = status_q;
                REG_CNT_SEL: PRDATA = {27'h0, cnt_sel_q};
                REG_CNT:     PRDATA = 32'(cnt_q);
                default:     PRDATA = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_event_conditioner.sv
// Directed bench for apb_event_conditioner; expectations are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_apb_event_conditioner;

    logic        HCLK;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] event_i;
    logic [31:0] signal_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    apb_event_conditioner #(
        .APB_ADDR_WIDTH(12),
        .SYNC_STAGES   (2),
        .CNT_WIDTH     (16)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .event_i (event_i),
        .signal_o(signal_o)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
        $display("[TB] %s observed %h expected %h", t, obs, e);
    endtask

    task automatic chk_sig(input string tag, input logic [31:0] v);
        push_exp(tag, v);
        pop_chk(signal_o);
    endtask

    // Called at a negedge; the write lands on the posedge just before the task returns.
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = addr;
        PWDATA  = data;
        PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read_chk(input string tag, input logic [11:0] addr, input logic [31:0] v);
        logic [31:0] d;
        push_exp(tag, v);
        PSEL    = 1'b1;
        PWRITE  = 1'b0;
        PADDR   = addr;
        PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        pop_chk(d);
        @(negedge HCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        HRESETn = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PWRITE  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        event_i = 32'hFFFF_FFFF;

        // reset with every line high; rising mode programmed as reset releases
        repeat (3) @(negedge HCLK);
        chk_sig("rst_signal", 32'h0);
        push_exp("rst_prdata", 32'h0);
        pop_chk(PRDATA);
        push_exp("pready", 32'h1);
        pop_chk({31'h0, PREADY});
        push_exp("pslverr", 32'h0);
        pop_chk({31'h0, PSLVERR});

        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h5555_5555; PENABLE = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        PENABLE = 1'b1;
        @(negedge HCLK);
        PADDR = 12'h004; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        for (int n = 0; n < 6; n++) begin
            chk_sig("warmup_signal", 32'h0);
            @(negedge HCLK);
        end
        apb_read_chk("warmup_status", 12'h00C, 32'h0);
        apb_read_chk("mode_lo_rd", 12'h000, 32'h5555_5555);
        apb_read_chk("mode_hi_rd", 12'h004, 32'h5555_5555);

        // line 3 rising edge: falling edges first must give nothing
        event_i = 32'h0;
        repeat (5) @(negedge HCLK);
        chk_sig("fall_in_rise_mode", 32'h0);
        event_i[3] = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge HCLK);
            chk_sig($sformatf("rise3_cyc%0d", n), (n == 3) ? 32'h8 : 32'h0);
        end
        apb_read_chk("rise3_status", 12'h00C, 32'h8);
        apb_write(12'h00C, 32'h8);
        apb_read_chk("rise3_w1c", 12'h00C, 32'h0);

        // line 7 any-edge with a 5-cycle pulse
        apb_write(12'h000, 32'h5555_D555);
        apb_write(12'h010, 32'd7);
        apb_write(12'h014, 32'h0);
        event_i[7] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge HCLK);
            chk_sig($sformatf("any7_cyc%0d", n), (n == 3 || n == 8) ? 32'h80 : 32'h0);
            if (n == 5) event_i[7] = 1'b0;
        end
        apb_read_chk("any7_cnt", 12'h014, 32'd2);
        apb_read_chk("any7_status", 12'h00C, 32'h80);

        // line 0 level mode behind a mask
        apb_write(12'h008, 32'h1);
        apb_write(12'h000, 32'h5555_D554);
        apb_write(12'h00C, 32'hFFFF_FFFF);
        event_i[0] = 1'b1;
        repeat (4) @(negedge HCLK);
        chk_sig("masked_level", 32'h0);
        apb_read_chk("masked_status", 12'h00C, 32'h0);
        apb_write(12'h008, 32'h0);
        chk_sig("unmask_t0", 32'h0);
        @(negedge HCLK);
        chk_sig("unmask_t1", 32'h1);
        event_i[0] = 1'b0;
        repeat (4) @(negedge HCLK);
        apb_write(12'h00C, 32'hFFFF_FFFF);
        apb_read_chk("status_cleared", 12'h00C, 32'h0);

        // line 5 detect collides with W1C of the same bit
        event_i[5] = 1'b1;
        @(negedge HCLK);
        apb_write(12'h00C, 32'h20);
        chk_sig("w1c_race_signal", 32'h20);
        apb_read_chk("w1c_race_status", 12'h00C, 32'h20);
        apb_write(12'h00C, 32'h20);
        apb_read_chk("w1c_later", 12'h00C, 32'h0);

        // unmapped index
        apb_write(12'h018, 32'hFFFF_FFFF);
        apb_read_chk("unmapped_6", 12'h018, 32'h0);
        apb_read_chk("unmapped_7", 12'h01C, 32'h0);

        // counter saturation on line 0 in level mode, one event per cycle
        apb_write(12'h010, 32'd0);
        apb_write(12'h014, 32'h0);
        event_i[0] = 1'b1;
        repeat (66000) @(negedge HCLK);
        apb_read_chk("cnt_sat", 12'h014, 32'h0000_FFFF);
        repeat (10) @(negedge HCLK);
        apb_read_chk("cnt_sat_more", 12'h014, 32'h0000_FFFF);
        apb_write(12'h010, 32'd5);
        apb_read_chk("cnt_sel_keeps", 12'h014, 32'h0000_FFFF);

        // clear write coincides with a line-5 rising edge
        event_i[5] = 1'b0;
        repeat (4) @(negedge HCLK);
        event_i[5] = 1'b1;
        @(negedge HCLK);
        apb_write(12'h014, 32'h0);
        chk_sig("cnt_clr_signal", 32'h21);
        apb_read_chk("cnt_clr_event", 12'h014, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
